// File: rtl/div_unit.sv
// div_unit: 32-bit signed sequential divider (restoring, one bit per cycle).
// Produces MIPS DIV results: lo = quotient truncated toward zero,
// hi = remainder carrying the sign of the dividend. Division by zero is
// flagged on divZero and leaves hi/lo untouched.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        divControl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        divDone,
    output logic        divZero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } stateT;

    stateT       state;

    // Working registers for the restoring loop
    logic [31:0] remReg;       // partial remainder magnitude
    logic [31:0] quoReg;       // dividend bits shifting out / quotient bits shifting in
    logic [32:0] divisorMag;   // |b|, 33 bits so that |0x80000000| is exact
    logic        quoSign;      // sign of the final quotient
    logic        remSign;      // sign of the final remainder (sign of dividend)
    logic [5:0]  iterCount;    // completed restoring steps

    // Operand magnitudes and one restoring step
    logic [32:0] absA;
    logic [32:0] absB;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic [31:0] nextRem;
    logic [31:0] nextQuo;

    // Bits that are provably zero by construction and therefore never read
    logic [1:0]  unusedBits;

    // Sign-extend to 33 bits before negating so the most negative input
    // yields +2^31 rather than wrapping back to itself.
    always_comb begin
        absA = a[31] ? (33'd0 - {a[31], a}) : {a[31], a};
        absB = b[31] ? (33'd0 - {b[31], b}) : {b[31], b};
    end

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor,
    // keep the difference when it did not borrow, otherwise restore.
    always_comb begin
        shifted = {remReg, quoReg[31]};
        diff    = {1'b0, shifted} - {1'b0, divisorMag};
        nextRem = remReg;
        nextQuo = {quoReg[30:0], 1'b0};
        if (diff[33]) begin
            nextRem = shifted[31:0];
            nextQuo = {quoReg[30:0], 1'b0};
        end else begin
            nextRem = diff[31:0];
            nextQuo = {quoReg[30:0], 1'b1};
        end
    end

    // absA[32] is zero for every 32-bit input; diff[32] is zero whenever the
    // step succeeds because the remainder stays below the divisor.
    assign unusedBits = {absA[32], diff[32]};

    // Control FSM with registered outputs and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remReg     <= '0;
            quoReg     <= '0;
            divisorMag <= '0;
            quoSign    <= 1'b0;
            remSign    <= 1'b0;
            iterCount  <= '0;
            hi         <= '0;
            lo         <= '0;
            busy       <= 1'b0;
            divDone    <= 1'b0;
            divZero    <= 1'b0;
        end else begin
            divDone <= 1'b0;
            divZero <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (divControl) begin
                        if (b == '0) begin
                            divZero <= 1'b1;
                        end else begin
                            remReg     <= '0;
                            quoReg     <= absA[31:0];
                            divisorMag <= absB;
                            quoSign    <= a[31] ^ b[31];
                            remSign    <= a[31];
                            iterCount  <= '0;
                            busy       <= 1'b1;
                            state      <= CALC;
                        end
                    end
                end

                CALC: begin
                    busy      <= 1'b1;
                    remReg    <= nextRem;
                    quoReg    <= nextQuo;
                    iterCount <= iterCount + 6'd1;
                    if (iterCount == 6'd31) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    lo      <= quoSign ? (32'd0 - quoReg) : quoReg;
                    hi      <= remSign ? (32'd0 - remReg) : remReg;
                    divDone <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        divControl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        divDone;
    logic        divZero;

    int nTests;
    int nFail;
    int cycles;

    div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .divControl (divControl),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .divDone    (divDone),
        .divZero    (divZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advances until divDone is seen or the budget runs out; returns edges taken.
    task automatic waitDone(output int n);
        n = 0;
        while (divDone !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    // Full transaction: pulse divControl for one edge, then check timing and result.
    task automatic runDiv(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] expLo, input logic [31:0] expHi);
        int n;
        int busyCnt;
        a = x;
        b = y;
        divControl = 1'b1;
        tick();
        divControl = 1'b0;
        chk({tag, "_busyStart"}, {31'd0, busy}, 32'd1);
        chk({tag, "_noZero"}, {31'd0, divZero}, 32'd0);
        n = 0;
        busyCnt = 0;
        while (divDone !== 1'b1 && n < 50) begin
            if (busy === 1'b1) busyCnt++;
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 32'd33);
        chk({tag, "_busyCycles"}, busyCnt, 32'd33);
        chk({tag, "_lo"}, lo, expLo);
        chk({tag, "_hi"}, hi, expHi);
        chk({tag, "_busyEnd"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_donePulse"}, {31'd0, divDone}, 32'd0);
    endtask

    initial begin
        nTests = 0;
        nFail = 0;
        reset = 1'b1;
        divControl = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, divDone}, 32'd0);
        chk("rst_zero", {31'd0, divZero}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic and signed cases
        runDiv("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        runDiv("dm7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        runDiv("d7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);

        // Divide by zero: flag only, hi/lo keep 7/-2 result
        a = 32'd5;
        b = 32'd0;
        divControl = 1'b1;
        tick();
        divControl = 1'b0;
        chk("dz_flag", {31'd0, divZero}, 32'd1);
        chk("dz_busy", {31'd0, busy}, 32'd0);
        chk("dz_done", {31'd0, divDone}, 32'd0);
        chk("dz_lo", lo, 32'hFFFF_FFFD);
        chk("dz_hi", hi, 32'd1);
        tick();
        chk("dz_pulse", {31'd0, divZero}, 32'd0);
        chk("dz_busy2", {31'd0, busy}, 32'd0);
        chk("dz_done2", {31'd0, divDone}, 32'd0);

        // Most-negative dividend boundaries
        runDiv("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        runDiv("dmin_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
        runDiv("d3_10", 32'd3, 32'd10, 32'd0, 32'd3);

        // Second request while busy is ignored
        a = 32'd1000;
        b = 32'd10;
        divControl = 1'b1;
        tick();
        divControl = 1'b0;
        repeat (9) tick();
        a = 32'd9;
        b = 32'd3;
        divControl = 1'b1;
        tick();
        divControl = 1'b0;
        waitDone(cycles);
        chk("ign_latency", cycles, 32'd23);
        chk("ign_lo", lo, 32'd100);
        chk("ign_hi", hi, 32'd0);
        tick();

        // Reset in the middle of CALC aborts, then a fresh start completes
        a = 32'd50;
        b = 32'd3;
        divControl = 1'b1;
        tick();
        divControl = 1'b0;
        repeat (14) tick();
        chk("abort_busyBefore", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_done", {31'd0, divDone}, 32'd0);
        tick();
        chk("abort_done2", {31'd0, divDone}, 32'd0);
        runDiv("d1234_m5", 32'd1234, 32'hFFFF_FFFB, 32'hFFFF_FF0A, 32'd4);

        // divControl held high restarts one cycle after divDone
        a = 32'd20;
        b = 32'd6;
        divControl = 1'b1;
        tick();
        waitDone(cycles);
        chk("hold_latency", cycles, 32'd33);
        chk("hold_lo", lo, 32'd3);
        chk("hold_hi", hi, 32'd2);
        tick();
        chk("hold_restart", {31'd0, busy}, 32'd1);
        divControl = 1'b0;
        waitDone(cycles);
        chk("hold_latency2", cycles, 32'd33);
        chk("hold_lo2", lo, 32'd3);
        chk("hold_hi2", hi, 32'd2);
        tick();

        // Reset wins over a simultaneous start request
        a = 32'd1;
        b = 32'd1;
        reset = 1'b1;
        divControl = 1'b1;
        tick();
        reset = 1'b0;
        divControl = 1'b0;
        chk("prio_busy", {31'd0, busy}, 32'd0);
        chk("prio_lo", lo, 32'd0);
        chk("prio_hi", hi, 32'd0);
        tick();
        chk("prio_busy2", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 divControl  input  1  start request from the control unit, sampled only in IDLE.
REQ-005 a  input  32  signed dividend, taken from register A.
REQ-006 b  input  32  signed divisor, taken from register B.
REQ-007 hi  output  32  registered remainder, written into the HI register path.
REQ-008 lo  output  32  registered quotient, written into the LO register path.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 divDone  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-011 divZero  output  1  one-cycle pulse flagging division by zero to exception control.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, CALC and FIX.
REQ-013 In IDLE, divControl=1 with b!=0 at edge N SHALL latch |a| and |b|, record the quotient sign (a[31]^b[31]) and remainder sign (a[31]), clear the 6-bit iteration counter, and enter CALC.
REQ-014 CALC SHALL perform one restoring step per cycle: shift {rem,quo} left 1 bit, subtract the divisor magnitude, keep the difference and set the quotient LSB to 1 when it is non-negative, else restore and set the quotient LSB to 0.
REQ-015 CALC SHALL run exactly 32 cycles (edges N+1..N+32), then enter FIX.
REQ-016 FIX SHALL, at edge N+33, load lo with the quotient (negated if the quotient sign is 1) and hi with the remainder (negated if the remainder sign is 1), assert divDone, and return to IDLE.
REQ-017 Results SHALL follow MIPS DIV semantics: quotient truncated toward zero; remainder zero or with the sign of the dividend.
REQ-018 Magnitudes SHALL be computed as 33-bit values so that a=0x80000000 is handled exactly.
REQ-019 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000, with no flag raised.
REQ-020 divControl=1 in IDLE with b==0 SHALL assert divZero for one cycle after edge N, leave hi/lo unchanged, keep busy=0, and stay in IDLE.
REQ-021 busy SHALL be 1 in CALC and FIX and 0 in IDLE.
REQ-022 divControl SHALL be ignored while busy=1; a, b and divControl SHALL not be sampled again until IDLE.
REQ-023 hi/lo SHALL hold their last value until the next successful division or reset.
REQ-024 divDone and divZero SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per event.
REQ-025 divControl held high continuously SHALL start a new division on the first IDLE edge after completion, one cycle after the divDone edge.

Reset
REQ-026 reset=1 SHALL, at the next edge, force IDLE and set hi=0, lo=0, busy=0, divDone=0, divZero=0, and the counter and internal registers to 0.
REQ-027 reset during CALC or FIX SHALL abort the operation with no divDone pulse, and hi/lo SHALL read 0.
REQ-028 reset SHALL take priority over divControl in the same cycle.

Verification
REQ-029 a=100, b=7, divControl pulsed at edge N -> busy high for edges N+1..N+33, lo=14, hi=2, divDone=1 after edge N+33 only.
REQ-030 a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=7, b=-2 -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-031 a=5, b=0 -> divZero=1 for one cycle after edge N, busy=0, hi/lo keep their prior values, no divDone pulse.
REQ-032 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; a=0x80000000, b=1 -> lo=0x80000000, hi=0.
REQ-033 A second divControl pulse at N+10 with different operands -> ignored; the result equals the first operation's.
REQ-034 reset asserted at N+15 -> the next cycle shows busy=0, hi=lo=0, and no divDone; a new start at N+17 completes normally at N+50.
